instr_loader: RTL

//  Writer side of the instruction RAM. The fetch stage only reads this RAM; this block fills it.

---
 rtl/instr_loader_pkg.sv | 19 +
 rtl/instr_loader_byte_packer.sv | 46 ++++
 rtl/instr_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and word geometry.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (adds the CHK state).
package instr_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd6
`ifdef INSTR_LOADER_CHECKSUM_EN
    , ST_CHK = 3'd5
`endif
  } state_t;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Packs accepted bytes little-endian into one 32-bit word; first byte lands in [7:0].
// word_o already includes the byte being pushed so the caller can latch a full word
// on the same edge that accepts the 4th byte.
module byte_packer
  import instr_loader_pkg::*;
(
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic                          clear_i,
  input  logic                          push_i,
  input  logic [7:0]                    byte_i,
  output logic [BYTES_PER_WORD*8-1:0]   word_o,
  output logic                          word_ready_o
);

  logic [1:0]                  cnt_q, cnt_d;
  logic [BYTES_PER_WORD*8-1:0] word_q, word_d;

  assign word_o       = {byte_i, word_q[BYTES_PER_WORD*8-1:8]};
  assign word_ready_o = push_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

  // Next byte count and shift register contents.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (push_i) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = word_o;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction RAM loader: receives a length-prefixed byte stream, packs it into
// 32-bit words and writes them to consecutive addresses from 0 while stalling the CPU.
// Optional feature macro: INSTR_LOADER_CHECKSUM_EN (XOR trailer byte, drives error).
module instr_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              cpu_stall,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_done
);
  import instr_loader_pkg::*;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t END_ST = ST_CHK;
`else
  localparam state_t END_ST = ST_DONE;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] len_full, idx_inc;
  logic [DATA_W-1:0] packed_word;
  logic              accept, start_acc, push, word_ready;

  assign rx_ready   = (state_q == ST_LEN0) || (state_q == ST_LEN1) || (state_q == ST_DATA)
`ifdef INSTR_LOADER_CHECKSUM_EN
                   || (state_q == ST_CHK)
`endif
                   ;
  assign accept     = rx_valid && rx_ready;
  assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign push       = accept && (state_q == ST_DATA);
  assign len_full   = ADDR_W'({rx_data, len_q[7:0]});
  assign idx_inc    = idx_q + ADDR_W'(1);

  assign mem_wren   = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_stall  = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign words_done = idx_q;

  byte_packer u_packer (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .clear_i      (start_acc),
    .push_i       (push),
    .byte_i       (rx_data),
    .word_o       (packed_word),
    .word_ready_o (word_ready)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  logic       err_q, err_d;
  assign error = err_q;
`else
  assign error = 1'b0;
`endif

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    err_d   = err_q;
    if (accept) chk_d = chk_q ^ rx_data;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_acc) begin
          state_d = ST_LEN0;
          idx_d   = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
          chk_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_LEN0: begin
        if (accept) begin
          len_d   = ADDR_W'(rx_data);
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_d   = len_full;
          state_d = (len_full == '0) ? END_ST : ST_DATA;
        end
      end
      ST_DATA: begin
        // Latch address and word here so they hold steady after WRITE.
        if (push && word_ready) begin
          addr_d  = idx_q;
          wdata_d = packed_word;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? END_ST : ST_DATA;
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          err_d   = (rx_data != chk_q);
          state_d = ST_DONE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  // Running checksum and mismatch flag.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chk_q <= '0;
      err_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      err_q <= err_d;
    end
  end
`endif

endmodule
